gate_bist_checker: RTL and testbench

Synthesizable stimulus-and-response engine for exercising a single 2-input combinational gate (and_gate, or_gate, …) in hardware, the on-chip counterpart of the simulation benches. It drives the gate's `a`/`b` inputs through all four vectors, samples the gate's `y` after a settle interval, and compares it with an expected truth table. It accumulates a mismatch count and a per-vector failure mask, and reports pass/fail when the run completes.

---
 rtl/gate_bist_checker.sv | 137 +++++++++++++
 tb/tb_gate_bist_checker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gate_bist_checker.sv
// On-chip stimulus/response checker for a single 2-input gate: sweeps {a,b}, samples y, tallies mismatches.
// Optional: define GATE_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module gate_bist_checker #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   pass_cnt, pass_cnt_n;
  logic [CNT_W-1:0]   settle_cnt, settle_cnt_n;
  logic               a_n, b_n, busy_n, done_n, pass_n;
  logic [3:0]         err_cnt_n, fail_vec_n;
  logic               mismatch, last_vec, stop;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      pass_cnt   <= pass_cnt_n;
      settle_cnt <= settle_cnt_n;
      a_out      <= a_n;
      b_out      <= b_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_cnt    <= err_cnt_n;
      fail_vec   <= fail_vec_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    pass_cnt_n   = pass_cnt;
    settle_cnt_n = settle_cnt;
    a_n          = a_out;
    b_n          = b_out;
    busy_n       = busy;
    done_n       = 1'b0;
    pass_n       = pass;
    err_cnt_n    = err_cnt;
    fail_vec_n   = fail_vec;
    mismatch     = 1'b0;
    last_vec     = 1'b0;
    stop         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n      = S_DRIVE;
          err_cnt_n    = '0;
          fail_vec_n   = '0;
          pass_n       = 1'b0;
          busy_n       = 1'b1;
          idx_n        = '0;
          pass_cnt_n   = '0;
          settle_cnt_n = '0;
          a_n          = 1'b0;
          b_n          = 1'b0;
        end
      end
      S_DRIVE: begin
        if (settle_cnt == CNT_W'(SETTLE - 1)) begin
          state_n = S_SAMPLE;
        end else begin
          settle_cnt_n = settle_cnt + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        mismatch = (y_in != TRUTH[idx]);
        last_vec = (idx == IDX_W'(3)) && (pass_cnt == CNT_W'(PASSES - 1));
        if (mismatch) begin
          err_cnt_n  = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;
          fail_vec_n = fail_vec | 4'(4'b0001 << idx);
        end
        idx_n        = idx + IDX_W'(1);
        settle_cnt_n = '0;
        if (idx == IDX_W'(3)) begin
          pass_cnt_n = pass_cnt + CNT_W'(1);
        end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        stop = last_vec | mismatch;
`else
        stop = last_vec;
`endif
        // The stimulus is left on the last (or failing) vector when the run ends
        if (stop) begin
          state_n = S_DONE;
        end else begin
          state_n    = S_DRIVE;
          {a_n, b_n} = idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
        pass_n  = (err_cnt == 4'd0);
        busy_n  = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: three instances (PASSES=1/3/15) driven by a modelled gate.
// Expectations follow GATE_BIST_STOP_ON_FAIL_EN when it is defined.
`timescale 1ns/1ps
module tb_gate_bist_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] y_v, a_v, b_v, busy_v, done_v, pass_v;
  logic [3:0] err_v  [3];
  logic [3:0] fail_v [3];
  int         mode;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] ab_seq [0:15];
  int         busy_e1;

  always #5 clk = ~clk;

  // Gate model: 0 AND, 1 stuck-0, 2 OR, 3 stuck-1, 4 NAND
  function automatic logic resp(input int m, input logic a, input logic b);
    case (m)
      0: resp = a & b;
      1: resp = 1'b0;
      2: resp = a | b;
      3: resp = 1'b1;
      default: resp = ~(a & b);
    endcase
  endfunction

  assign y_v[0] = resp(mode, a_v[0], b_v[0]);
  assign y_v[1] = resp(mode, a_v[1], b_v[1]);
  assign y_v[2] = resp(mode, a_v[2], b_v[2]);

  gate_bist_checker u_p1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .y_in(y_v[0]),
    .a_out(a_v[0]), .b_out(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_cnt(err_v[0]), .fail_vec(fail_v[0])
  );

  gate_bist_checker #(.PASSES(3)) u_p3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .y_in(y_v[1]),
    .a_out(a_v[1]), .b_out(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_cnt(err_v[1]), .fail_vec(fail_v[1])
  );

  gate_bist_checker #(.PASSES(15)) u_p15 (
    .clk(clk), .rst(rst), .start(start_v[2]), .y_in(y_v[2]),
    .a_out(a_v[2]), .b_out(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_cnt(err_v[2]), .fail_vec(fail_v[2])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start on one instance and count edges after acceptance until done (-1 on timeout)
  task automatic do_run(input int idx, input int repulse, output int lat);
    lat = -1;
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (idx == 0 && n < 16) ab_seq[n] = {a_v[0], b_v[0]};
      if (idx == 0 && n == 1) busy_e1 = int'(busy_v[0]);
      start_v[idx] = (n == repulse) ? 1'b1 : 1'b0;
      if (done_v[idx]) begin
        lat = n;
        break;
      end
    end
    start_v[idx] = 1'b0;
  endtask

  task automatic check_result(input string tag, input int idx, input int lat, input int exp_lat,
                              input int exp_err, input int exp_fail, input int exp_pass);
    check({tag, "_lat"},  lat, exp_lat);
    check({tag, "_err"},  int'(err_v[idx]), exp_err);
    check({tag, "_fail"}, int'(fail_v[idx]), exp_fail);
    check({tag, "_pass"}, int'(pass_v[idx]), exp_pass);
    check({tag, "_busy"}, int'(busy_v[idx]), 0);
  endtask

  initial begin
    int lat;
    int seen;
    rst     = 1'b1;
    start_v = '0;
    mode    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a",    int'(a_v[0]), 0);
    check("rst_b",    int'(b_v[0]), 0);
    check("rst_busy", int'(busy_v[0]), 0);
    check("rst_done", int'(done_v[0]), 0);
    check("rst_pass", int'(pass_v[0]), 0);
    check("rst_err",  int'(err_v[0]), 0);
    check("rst_fail", int'(fail_v[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    // Good AND gate, with start re-pulsed mid-run (must be ignored)
    mode = 0;
    do_run(0, 5, lat);
    check_result("and", 0, lat, 13, 0, 0, 1);
    check("and_busy_e1", busy_e1, 1);
    check("and_ab_e2", int'(ab_seq[2]), 0);
    check("and_ab_e3", int'(ab_seq[3]), 1);
    check("and_ab_e6", int'(ab_seq[6]), 2);
    check("and_ab_e9", int'(ab_seq[9]), 3);
    @(posedge clk); #1;
    check("and_done_1cyc", int'(done_v[0]), 0);
    check("and_pass_held", int'(pass_v[0]), 1);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    mode = 1; do_run(0, 0, lat); check_result("zero", 0, lat, 13, 1, 8, 0);
    check("zero_ab", int'({a_v[0], b_v[0]}), 3);
    mode = 2; do_run(0, 0, lat); check_result("or", 0, lat, 7, 1, 2, 0);
    check("or_ab", int'({a_v[0], b_v[0]}), 1);
    mode = 3; do_run(0, 0, lat); check_result("one", 0, lat, 4, 1, 1, 0);
    check("one_ab", int'({a_v[0], b_v[0]}), 0);
    mode = 1; do_run(1, 0, lat); check_result("p3_zero", 1, lat, 13, 1, 8, 0);
    mode = 4; do_run(2, 0, lat); check_result("p15_nand", 2, lat, 4, 1, 1, 0);
`else
    mode = 1; do_run(0, 0, lat); check_result("zero", 0, lat, 13, 1, 8, 0);
    check("zero_ab", int'({a_v[0], b_v[0]}), 3);
    mode = 2; do_run(0, 0, lat); check_result("or", 0, lat, 13, 2, 6, 0);
    mode = 3; do_run(0, 0, lat); check_result("one", 0, lat, 13, 3, 7, 0);
    mode = 1; do_run(1, 0, lat); check_result("p3_zero", 1, lat, 37, 3, 8, 0);
    mode = 4; do_run(2, 0, lat); check_result("p15_nand", 2, lat, 181, 15, 15, 0);
`endif

    // Reset at edge 8 of a run: everything clears at once and no done follows
    mode = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_busy", int'(busy_v[0]), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_a",    int'(a_v[0]), 0);
    check("mid_rst_b",    int'(b_v[0]), 0);
    check("mid_rst_busy", int'(busy_v[0]), 0);
    check("mid_rst_done", int'(done_v[0]), 0);
    check("mid_rst_pass", int'(pass_v[0]), 0);
    check("mid_rst_err",  int'(err_v[0]), 0);
    check("mid_rst_fail", int'(fail_v[0]), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) seen++;
    end
    check("mid_rst_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
